mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Iterative shift-and-add multiplier sequencer for the Pipelined datapath's MUL path.
//  It owns no adder: it drives one external 64-bit combinational adder (adder_64)
//  through add_a/add_b/add_sum, one partial-product accumulation per cycle.
//  Produces the low WIDTH bits of op_a*op_b (unsigned, mod 2^WIDTH) with start/done handshake.
// PARAMETERS
//  WIDTH   64  operand/result/adder width
//  CNT_W   7   iteration counter width; must hold WIDTH (clog2(WIDTH)+1)
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  reset    in   1      asynchronous, active-high; clears all state immediately
//  start    in   1      request; sampled only when ready=1
//  op_a     in   WIDTH  multiplicand, captured on accepted start
//  op_b     in   WIDTH  multiplier, captured on accepted start
//  ready    out  1      high only in IDLE; start accepted iff start&ready at clk edge
//  done     out  1      one-cycle pulse, result valid
//  result   out  WIDTH  product low bits; held from done until next accepted start completes
//  add_a    out  WIDTH  to adder A input
//  add_b    out  WIDTH  to adder B input
//  add_sum  in   WIDTH  from adder sum output (combinational, same cycle)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, acc/M/Q/count/result=0; ready=1, done=0.
//  - Registers: acc (accumulator), M (shifted multiplicand), Q (shifted multiplier), count.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: ready=1. On start: M<=op_a, Q<=op_b, acc<=0, count<=0;
//          next=RUN if op_b!=0, else DONE (result<=0).
//    RUN : add_a=acc, add_b=Q[0]?M:0; acc<=add_sum; M<=M<<1; Q<=Q>>1; count<=count+1.
//          Leave for DONE when shifted Q (Q>>1)==0 or count+1==WIDTH; result<=add_sum that edge.
//    DONE: done=1 for exactly this cycle; next=IDLE unconditionally.
//  - Early termination: RUN iterations k = bit-length of op_b (index of MSB set +1), 0..WIDTH.
//  - Latency: start sampled at edge E0; done high in cycle after edge E0+k
//    (k=0 -> cycle after E0). Next start accepted at edge E0+k+2.
//  - add_a/add_b = 0 whenever state!=RUN (no spurious toggling on shared adder).
//  - Arithmetic: adder carry-out discarded; overflow beyond WIDTH silently wraps.
//    M<<1 drops its MSB; no sign handling.
//  - start while RUN or DONE: ignored, no effect on operands or result.
//  - op_a/op_b may change freely after acceptance; captured copies are used.
//  - result changes only at RUN->DONE or IDLE->DONE transitions; stable otherwise.
//  - Reset mid-RUN: operation aborted, no done pulse, result=0.
// TESTING
//  1. op_a=3, op_b=5, start 1 cycle -> done 1 cycle after E0+3, result=15, ready back next cycle.
//  2. op_a=0x1234, op_b=0 -> done in cycle after E0, result=0, no RUN cycles, add_b stays 0.
//  3. op_a=op_b=64'hFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles, done after E0+64, result=64'h1.
//  4. op_a=7, op_b=64'h8000_0000_0000_0000 -> k=64, result=64'h8000_0000_0000_0000;
//     assert start with op_a=9,op_b=9 mid-RUN -> ignored, result unchanged by it.
//  5. Start 6*7 then assert reset at E0+2 (async, between edges) -> ready=1, done=0,
//     result=0 immediately; following start 6*7 -> result=42, done after E0'+3.
//  6. Back-to-back: hold start high continuously with changing operands -> each accepted
//     only when ready=1; 10 random pairs compared against (a*b) mod 2^64, latency per k.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-and-add multiplier sequencer.
// Drives an external adder, one partial product per cycle.
module mult_seq_ctrl #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             last;

   assign cnt_inc = cnt + 1'b1;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state, handshake and adder operand selection
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      add_a     = '0;
      add_b     = '0;
      last      = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start)
               state_nxt = (op_b != '0) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            add_a = acc;
            add_b = q[0] ? m : '0;
            last  = ((q >> 1) == '0) ||
                    (cnt_inc == CNT_W'(WIDTH));
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, accumulation and result latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         m      <= '0;
         q      <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m   <= op_a;
                  q   <= op_b;
                  acc <= '0;
                  cnt <= '0;
                  if (op_b == '0) result <= '0;
               end
            end
            S_RUN: begin
               acc <= add_sum;
               m   <= m << 1;
               q   <= q >> 1;
               cnt <= cnt_inc;
               if (last) result <= add_sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl.
// Driver pushes expected products; monitor checks on done.
module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        ready;
   logic        done;
   logic [63:0] result;
   logic [63:0] add_a;
   logic [63:0] add_b;
   logic [63:0] add_sum;

   typedef struct {
      logic [63:0] r;
      int          c;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          total = 0;
   int          passed = 0;
   logic [63:0] held = '0;
   logic        prev_done = 1'b0;
   bit          drv_done = 1'b0;

   mult_seq_ctrl #(.WIDTH(64), .CNT_W(7)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op_a(op_a),
      .op_b(op_b),
      .ready(ready),
      .done(done),
      .result(result),
      .add_a(add_a),
      .add_b(add_b),
      .add_sum(add_sum)
   );

   assign add_sum = add_a + add_b;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic int blen(input logic [63:0] b);
      int k = 0;
      for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
      return k;
   endfunction

   // Waits for ready, presents one request, optionally scores it
   task automatic issue(input logic [63:0] a, input logic [63:0] b,
                        input bit push);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("ready_timeout", {63'd0, ready}, 64'd1);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      e.r   = a * b;
      e.c   = cyc + 1 + blen(b);
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = 64'hDEAD_BEEF_0BAD_F00D;
      op_b  = 64'h0123_4567_89AB_CDEF;
   endtask

   // Monitor: pops on done, also checks idle adder and held result
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         held      = '0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("ready_after_done", {63'd0, ready}, 64'd1);
         if (ready || done) begin
            chk("idle_add_a", add_a, 64'd0);
            chk("idle_add_b", add_b, 64'd0);
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.r);
               chk("done_cycle", 64'(cyc), 64'(e.c));
            end
            held = result;
         end else begin
            chk("result_held", result, held);
         end
         prev_done = done;
      end
   end

   initial begin
      int n;
      logic [63:0] a;
      logic [63:0] b;
      exp_t e;
      reset = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #2;
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", result, 64'd0);
      @(negedge clk);
      #1 reset = 1'b0;

      // 1: small product, k=3
      issue(64'd3, 64'd5, 1);
      // 2: zero multiplier, no RUN cycles
      issue(64'h1234, 64'd0, 1);
      // 3: all ones squared, 64 iterations
      issue('1, '1, 1);
      // 4: MSB-only multiplier with ignored start mid-run
      issue(64'd7, 64'h8000_0000_0000_0000, 1);
      repeat (5) begin
         @(negedge clk);
         start = 1'b1;
         op_a  = 64'd9;
         op_b  = 64'd9;
      end
      @(negedge clk);
      start = 1'b0;

      // 5: async reset mid-run aborts the operation
      issue(64'd6, 64'd7, 0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("abort_ready", {63'd0, ready}, 64'd1);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_result", result, 64'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      issue(64'd6, 64'd7, 1);

      // 6: start held high with operands changing every cycle
      n = 0;
      for (int c = 0; c < 3000 && n < 10; c++) begin
         @(negedge clk);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom} >> $urandom_range(0, 63);
         start = 1'b1;
         op_a  = a;
         op_b  = b;
         if (ready) begin
            e.r = a * b;
            e.c = cyc + 1 + blen(b);
            sb.push_back(e);
            n++;
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b_accepted", 64'(n), 64'd10);

      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      drv_done = 1'b1;
   end

   initial begin
      wait (drv_done);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
